// File: rtl/tanh4_rr_scheduler.sv
// Round-robin scheduler sharing one combinational 4-bit approximate tanh core among NREQ
// valid/ready requesters, with a single registered, tagged result channel.
module tanh4_rr_scheduler #(
    parameter int NREQ = 4,
    parameter int TAGW = 2,
    parameter int CNTW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [4*NREQ-1:0]    req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      cfg_mask,
    output logic                 res_valid,
    output logic [3:0]           res_data,
    output logic [TAGW-1:0]      res_tag,
    input  logic                 res_ready,
    output logic                 busy,
    output logic [CNTW-1:0]      op_count
);

    // Fixed activation curve; the table is cheaper to read than the bit identities.
    function automatic logic [3:0] tanh4(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'd0:    y = 4'd8;
            4'd1:    y = 4'd3;
            4'd2:    y = 4'd12;
            4'd3:    y = 4'd3;
            4'd4:    y = 4'd8;
            4'd5:    y = 4'd3;
            4'd6:    y = 4'd12;
            4'd7:    y = 4'd7;
            4'd8:    y = 4'd0;
            4'd9:    y = 4'd3;
            4'd10:   y = 4'd12;
            4'd11:   y = 4'd11;
            4'd12:   y = 4'd4;
            4'd13:   y = 4'd3;
            4'd14:   y = 4'd12;
            default: y = 4'd15;
        endcase
        return y;
    endfunction

    logic                r_res_valid;
    logic [3:0]          r_res_data;
    logic [TAGW-1:0]     r_res_tag;
    logic [TAGW-1:0]     r_rr_ptr;
    logic [CNTW-1:0]     r_op_count;

    logic [NREQ-1:0]     w_elig;
    logic                w_slot_free;
    logic                w_found;
    logic [TAGW-1:0]     w_grant_idx;
    logic [3:0]          w_grant_data;
    logic                w_grant_en;
    logic [TAGW-1:0]     w_next_ptr;

    assign w_elig      = req_valid & cfg_mask;
    assign w_slot_free = ~r_res_valid | res_ready;

    // Scan rr_ptr, rr_ptr+1, ... modulo NREQ; NREQ need not be a power of two,
    // so the wrap is an explicit subtract rather than a bit truncation.
    always_comb begin
        int idx;
        // NOTE: every output of this block gets a default first so no path leaves a latch.
        w_found      = 1'b0;
        w_grant_idx  = '0;
        w_grant_data = '0;
        idx          = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!w_found && w_elig[idx]) begin
                w_found      = 1'b1;
                w_grant_idx  = TAGW'(idx);
                w_grant_data = req_data[4*idx +: 4];
            end
        end
    end

    assign w_grant_en = w_found & w_slot_free & ~rst;
    assign req_ready  = w_grant_en ? (NREQ'(1) << w_grant_idx) : '0;
    assign w_next_ptr = (w_grant_idx == TAGW'(NREQ - 1)) ? '0 : w_grant_idx + TAGW'(1);

    // A grant always implies a transfer because req_ready is only raised where valid is set.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_tag   <= '0;
            r_rr_ptr    <= '0;
            r_op_count  <= '0;
        end else if (w_grant_en) begin
            r_res_valid <= 1'b1;
            r_res_data  <= tanh4(w_grant_data);
            r_res_tag   <= w_grant_idx;
            r_rr_ptr    <= w_next_ptr;
            r_op_count  <= r_op_count + CNTW'(1);
        end else if (r_res_valid && res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_tag   = r_res_tag;
    assign busy      = r_res_valid;
    assign op_count  = r_op_count;

endmodule

// File: tb/tb_tanh4_rr_scheduler.sv
// Scoreboard bench for tanh4_rr_scheduler: directed stimulus pushes expected results,
// a monitor pops them whenever a result handshake completes. A small NREQ=3/CNTW=4 instance covers wraps.
module tb_tanh4_rr_scheduler;

    localparam logic [3:0] F_TAB [16] = '{4'd8, 4'd3, 4'd12, 4'd3, 4'd8, 4'd3, 4'd12, 4'd7,
                                          4'd0, 4'd3, 4'd12, 4'd11, 4'd4, 4'd3, 4'd12, 4'd15};

    typedef struct {
        logic [1:0] tag;
        logic [3:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_data;
    logic [3:0]  req_ready;
    logic [3:0]  cfg_mask;
    logic        res_valid;
    logic [3:0]  res_data;
    logic [1:0]  res_tag;
    logic        res_ready;
    logic        busy;
    logic [15:0] op_count;

    logic        rst3;
    logic [2:0]  req_valid3;
    logic [11:0] req_data3;
    logic [2:0]  req_ready3;
    logic [2:0]  cfg_mask3;
    logic        res_valid3;
    logic [3:0]  res_data3;
    logic [1:0]  res_tag3;
    logic        res_ready3;
    logic        busy3;
    logic [3:0]  op_count3;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    tanh4_rr_scheduler #(.NREQ(4), .TAGW(2), .CNTW(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .cfg_mask(cfg_mask), .res_valid(res_valid),
        .res_data(res_data), .res_tag(res_tag), .res_ready(res_ready),
        .busy(busy), .op_count(op_count)
    );

    tanh4_rr_scheduler #(.NREQ(3), .TAGW(2), .CNTW(4)) dut3 (
        .clk(clk), .rst(rst3), .req_valid(req_valid3), .req_data(req_data3),
        .req_ready(req_ready3), .cfg_mask(cfg_mask3), .res_valid(res_valid3),
        .res_data(res_data3), .res_tag(res_tag3), .res_ready(res_ready3),
        .busy(busy3), .op_count(op_count3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int tag, input int x);
        exp_t e;
        e.tag  = 2'(tag);
        e.data = F_TAB[x];
        sb.push_back(e);
    endtask

    // Monitor: every completed result handshake must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (res_valid === 1'b1 && res_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got tag %0d data %0d, expected none", res_tag, res_data);
                end else begin
                    e = sb.pop_front();
                    check("res_tag", 32'(res_tag), 32'(e.tag));
                    check("res_data", 32'(res_data), 32'(e.data));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] mask_grants [4];
        mask_grants = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};

        rst = 1'b1; req_valid = 4'hF; req_data = '0; cfg_mask = 4'hF; res_ready = 1'b1;
        rst3 = 1'b1; req_valid3 = '0; req_data3 = '0; cfg_mask3 = 3'b111; res_ready3 = 1'b1;

        // Reset: two cycles, everything valid, no grant allowed.
        repeat (2) begin
            @(negedge clk);
            check("rst_req_ready", 32'(req_ready), 32'h0);
            @(posedge clk);
        end
        #1;
        rst = 1'b0; req_valid = '0;
        @(negedge clk);
        check("rst_res_valid", 32'(res_valid), 32'h0);
        check("rst_res_data", 32'(res_data), 32'h0);
        check("rst_res_tag", 32'(res_tag), 32'h0);
        check("rst_op_count", 32'(op_count), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);

        // Full sweep on requester 2, back-to-back.
        for (int x = 0; x < 16; x++) begin
            step();
            req_valid = 4'b0100;
            req_data  = 16'(x) << 8;
            push(2, x);
            @(negedge clk);
            check("sweep_ready", 32'(req_ready), 32'h4);
            if (x > 0) check("sweep_no_bubble", 32'(res_valid), 32'h1);
        end
        step();
        req_valid = '0;
        @(negedge clk);
        check("sweep_op_count", 32'(op_count), 32'd16);

        // Restart with rr_ptr=0, then all four requesters continuously valid.
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_valid = 4'hF;
        req_data  = {4'd11, 4'd10, 4'd9, 4'd8};
        for (int k = 0; k < 8; k++) begin
            push(k % 4, 8 + (k % 4));
            @(negedge clk);
            check("rr_ready", 32'(req_ready), 32'(1) << (k % 4));
            step();
        end
        req_valid = '0;
        @(negedge clk);

        // Back-pressure: f(13)=3 from requester 1 held for five cycles.
        step();
        req_valid = 4'b0010;
        req_data  = {4'd7, 4'd6, 4'd13, 4'd0};
        push(1, 13);
        @(negedge clk);
        check("bp_first_ready", 32'(req_ready), 32'h2);
        step();
        req_valid = 4'hF;
        res_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_ready_low", 32'(req_ready), 32'h0);
            check("bp_hold_valid", 32'(res_valid), 32'h1);
            check("bp_hold_data", 32'(res_data), 32'd3);
            check("bp_hold_tag", 32'(res_tag), 32'd1);
            check("bp_busy", 32'(busy), 32'h1);
            step();
        end
        res_ready = 1'b1;
        push(2, 6);
        @(negedge clk);
        check("bp_release_ready", 32'(req_ready), 32'h4);
        step();
        req_valid = '0;
        @(negedge clk);
        check("bp_no_bubble", 32'(res_valid), 32'h1);
        check("bp_op_count", 32'(op_count), 32'd10);

        // Reset mid-operation: a held result from requester 2 is dropped.
        step();
        req_valid = 4'b0100;
        res_ready = 1'b0;
        @(negedge clk);
        check("mid_grant", 32'(req_ready), 32'h4);
        step();
        req_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        check("mid_pre_valid", 32'(res_valid), 32'h1);
        check("mid_pre_tag", 32'(res_tag), 32'd2);
        check("mid_rst_ready", 32'(req_ready), 32'h0);
        step();
        rst = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        check("mid_post_valid", 32'(res_valid), 32'h0);
        check("mid_post_count", 32'(op_count), 32'h0);
        step();
        req_valid = 4'b1001;
        req_data  = {4'd11, 4'd10, 4'd9, 4'd8};
        push(0, 8);
        @(negedge clk);
        check("mid_lowest_grant", 32'(req_ready), 32'h1);

        // Mask 1010 with rr_ptr=1: grants 1,3,1,3.
        step();
        cfg_mask  = 4'b1010;
        req_valid = 4'hF;
        for (int k = 0; k < 4; k++) begin
            push((k % 2 == 0) ? 1 : 3, (k % 2 == 0) ? 9 : 11);
            @(negedge clk);
            check("mask_ready", 32'(req_ready), 32'(mask_grants[k]));
            step();
        end
        // Masking everyone: no grant, yet the result from requester 3 still drains.
        cfg_mask = 4'b0000;
        @(negedge clk);
        check("mask_none_ready", 32'(req_ready), 32'h0);
        check("mask_op_count", 32'(op_count), 32'd5);
        step();
        req_valid = '0;
        cfg_mask  = 4'hF;
        repeat (3) step();
        @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'h0);

        // NREQ=3, CNTW=4 instance: pointer wrap after requester 2 and counter wrap 15->0.
        step();
        rst3 = 1'b0;
        req_valid3 = 3'b111;
        req_data3  = {4'd2, 4'd1, 4'd0};
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            check("n3_ready", 32'(req_ready3), 32'(1) << (k % 3));
            if (k > 0) begin
                check("n3_tag", 32'(res_tag3), 32'((k - 1) % 3));
                check("n3_data", 32'(res_data3), 32'(F_TAB[(k - 1) % 3]));
                check("n3_op_count", 32'(op_count3), 32'(k % 16));
            end
            step();
        end
        req_valid3 = '0;
        repeat (2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
